// File: rtl/gb_sound_pkg.sv
// gb_sound_pkg: register map, duty table, length limits and mixing helpers for the Game Boy APU
package gb_sound_pkg;
  localparam int FS_DIV_DEF = 8192;
  localparam logic [15:0] A_NR10 = 16'hFF10, A_NR11 = 16'hFF11, A_NR12 = 16'hFF12, A_NR13 = 16'hFF13;
  localparam logic [15:0] A_NR14 = 16'hFF14, A_NR21 = 16'hFF16, A_NR22 = 16'hFF17, A_NR23 = 16'hFF18;
  localparam logic [15:0] A_NR24 = 16'hFF19, A_NR30 = 16'hFF1A, A_NR31 = 16'hFF1B, A_NR32 = 16'hFF1C;
  localparam logic [15:0] A_NR33 = 16'hFF1D, A_NR34 = 16'hFF1E, A_NR41 = 16'hFF20, A_NR42 = 16'hFF21;
  localparam logic [15:0] A_NR43 = 16'hFF22, A_NR44 = 16'hFF23, A_NR50 = 16'hFF24, A_NR51 = 16'hFF25;
  localparam logic [15:0] A_NR52 = 16'hFF26, A_WAVE = 16'hFF30, A_END = 16'hFF3F;
  // bit (7 - position) of each entry is the duty output at that step
  localparam logic [3:0][7:0] DUTY = {8'b01111110, 8'b10000111, 8'b10000001, 8'b00000001};
  localparam logic [6:0] LEN_SQ = 7'd64;
  localparam logic [8:0] LEN_WAVE = 9'd256;
  function automatic logic [4:0] ri(input logic [15:0] ad);
    return 5'(ad - A_NR10);
  endfunction
  function automatic logic [3:0] env_step(input logic [3:0] v, input logic up);
    return up ? (v == 4'hF ? v : v + 4'd1) : (v == 4'h0 ? v : v - 4'd1);
  endfunction
  function automatic logic [19:0] mix(input logic [3:0] m, input logic [15:0] c, input logic [2:0] v);
    logic [5:0] s;
    s = 6'd0;
    for (int i = 0; i < 4; i++) s = s + (m[i] ? {2'b0, c[4*i+:4]} : 6'd0);
    return {{3'b0, s} * ({6'b0, v} + 9'd1), 11'b0};
  endfunction
endpackage

// File: rtl/gb_sound_if.sv
// gb_sound_if: CPU I/O bus and audio sample outputs of the APU
interface gb_sound_if;
  logic [15:0] a;
  logic [7:0] dout, din;
  logic rd, wr;
  logic [19:0] left, right;
  modport master (output a, din, rd, wr, input dout, left, right);
  modport slave (input a, din, rd, wr, output dout, left, right);
endinterface

// File: rtl/gb_sound_square.sv
// gb_sound_square: square channel with frequency timer, duty sequencer, envelope and length counter
module gb_sound_square
  import gb_sound_pkg::*;
(
  input logic clk,
  input logic rst,
  input logic fs_tick,
  input logic [2:0] fs_step,
  input logic [7:0] nr1,
  input logic [7:0] nr2,
  input logic [10:0] freq,
  input logic len_en,
  input logic ld,
  input logic trig,
  output logic en,
  output logic [3:0] out
);
  logic [13:0] tmr, per;
  logic [2:0] pos, etmr;
  logic [6:0] len;
  logic [3:0] vol;
  logic dac, len_clk, env_clk;
  assign dac = |nr2[7:3];
  assign per = {12'd2048 - {1'b0, freq}, 2'b00};
  assign len_clk = fs_tick && !fs_step[0] && len_en && len != 7'd0;
  assign env_clk = fs_tick && fs_step == 3'd7 && nr2[2:0] != 3'd0;
  always_ff @(posedge clk)
    if (rst) begin
      en <= 1'b0;
      out <= 4'd0;
      tmr <= 14'd0;
      pos <= 3'd0;
      etmr <= 3'd0;
      len <= 7'd0;
      vol <= 4'd0;
    end else begin
      tmr <= tmr == 14'd0 ? per - 14'd1 : tmr - 14'd1;
      pos <= tmr == 14'd0 ? pos + 3'd1 : pos;
      if (ld) len <= LEN_SQ - {1'b0, nr1[5:0]};
      if (len_clk) len <= len - 7'd1;
      if (len_clk && len == 7'd1) en <= 1'b0;
      if (env_clk) etmr <= etmr <= 3'd1 ? nr2[2:0] : etmr - 3'd1;
      if (env_clk && etmr <= 3'd1) vol <= env_step(vol, nr2[3]);
      if (trig) begin
        en <= dac;
        tmr <= per - 14'd1;
        pos <= 3'd0;
        vol <= nr2[7:4];
        etmr <= nr2[2:0];
        if (len == 7'd0) len <= LEN_SQ;
      end
      if (!dac) en <= 1'b0;
      out <= en && DUTY[nr1[7:6]][3'd7 - pos] ? vol : 4'd0;
    end
endmodule

// File: rtl/gb_sound.sv
// gb_sound: Game Boy APU with register file, two square, wave and noise channels and stereo mixer
module gb_sound
  import gb_sound_pkg::*;
#(
  parameter int FS_DIV = FS_DIV_DEF
) (
  input logic clk,
  input logic rst,
  gb_sound_if.slave bus
);
  localparam int FW = $clog2(FS_DIV);
  logic [7:0] regs [22];
  logic [7:0] wave [16];
  logic [7:0] wb, nr30, nr32, nr34, nr42, nr43, nr44;
  logic pwr, chan_rst, fs_tick, wr_ok, in_regs, en1, en2, en3, en4;
  logic [FW-1:0] fs_cnt;
  logic [2:0] fs_step, etmr4;
  logic [3:0] ld, tr, en, out1, out2, out3, out4, vol4, smp;
  logic [12:0] tmr3, per3;
  logic [4:0] pos3;
  logic [8:0] len3;
  logic [6:0] len4;
  logic [21:0] tmr4, per4;
  logic [14:0] lfsr, lfsr_nx;
  logic [15:0] cv;
  assign nr30 = regs[ri(A_NR30)];
  assign nr32 = regs[ri(A_NR32)];
  assign nr34 = regs[ri(A_NR34)];
  assign nr42 = regs[ri(A_NR42)];
  assign nr43 = regs[ri(A_NR43)];
  assign nr44 = regs[ri(A_NR44)];
  assign chan_rst = rst || !pwr;
  assign wr_ok = bus.wr && pwr;
  assign in_regs = bus.a >= A_NR10 && bus.a <= A_NR51;
  assign fs_tick = fs_cnt == FW'(FS_DIV - 1);
  assign en = {en4, en3, en2, en1};
  always_ff @(posedge clk)
    if (rst) begin
      pwr <= 1'b0;
      ld <= 4'd0;
      tr <= 4'd0;
      for (int i = 0; i < 22; i++) regs[i] <= 8'd0;
      for (int i = 0; i < 16; i++) wave[i] <= 8'd0;
    end else begin
      // length loads and triggers act one cycle late so they see the freshly written registers
      ld <= {wr_ok && bus.a == A_NR41, wr_ok && bus.a == A_NR31, wr_ok && bus.a == A_NR21, wr_ok && bus.a == A_NR11};
      tr <= {wr_ok && bus.a == A_NR44, wr_ok && bus.a == A_NR34, wr_ok && bus.a == A_NR24, wr_ok && bus.a == A_NR14} & {4{bus.din[7]}};
      if (wr_ok && in_regs) regs[ri(bus.a)] <= bus.din;
      if (bus.wr && bus.a[15:4] == A_WAVE[15:4]) wave[bus.a[3:0]] <= bus.din;
      if (bus.wr && bus.a == A_NR52) pwr <= bus.din[7];
      if (bus.wr && bus.a == A_NR52 && !bus.din[7]) for (int i = 0; i < 22; i++) regs[i] <= 8'd0;
    end
  gb_sound_square u_sq1 (.clk(clk), .rst(chan_rst), .fs_tick(fs_tick), .fs_step(fs_step),
    .nr1(regs[ri(A_NR11)]), .nr2(regs[ri(A_NR12)]), .freq({regs[ri(A_NR14)][2:0], regs[ri(A_NR13)]}),
    .len_en(regs[ri(A_NR14)][6]), .ld(ld[0]), .trig(tr[0]), .en(en1), .out(out1));
  gb_sound_square u_sq2 (.clk(clk), .rst(chan_rst), .fs_tick(fs_tick), .fs_step(fs_step),
    .nr1(regs[ri(A_NR21)]), .nr2(regs[ri(A_NR22)]), .freq({regs[ri(A_NR24)][2:0], regs[ri(A_NR23)]}),
    .len_en(regs[ri(A_NR24)][6]), .ld(ld[1]), .trig(tr[1]), .en(en2), .out(out2));
  assign per3 = {12'd2048 - {1'b0, nr34[2:0], regs[ri(A_NR33)]}, 1'b0};
  assign wb = wave[pos3[4:1]];
  assign smp = pos3[0] ? wb[3:0] : wb[7:4];
  assign per4 = {15'd0, nr43[2:0] == 3'd0 ? 7'd8 : {nr43[2:0], 4'b0}} << nr43[7:4];
  assign lfsr_nx = {lfsr[0] ^ lfsr[1], lfsr[14:8], nr43[3] ? lfsr[0] ^ lfsr[1] : lfsr[7], lfsr[6:1]};
  always_ff @(posedge clk)
    if (chan_rst) begin
      fs_cnt <= '0;
      fs_step <= 3'd0;
      {en3, tmr3, pos3, len3, out3} <= '0;
      {en4, tmr4, lfsr, len4, vol4, etmr4, out4} <= '0;
    end else begin
      fs_cnt <= fs_tick ? '0 : fs_cnt + FW'(1);
      if (fs_tick) fs_step <= fs_step + 3'd1;
      tmr3 <= tmr3 == 13'd0 ? per3 - 13'd1 : tmr3 - 13'd1;
      pos3 <= tmr3 == 13'd0 ? pos3 + 5'd1 : pos3;
      if (ld[2]) len3 <= LEN_WAVE - {1'b0, regs[ri(A_NR31)]};
      if (fs_tick && !fs_step[0] && nr34[6] && len3 != 9'd0) len3 <= len3 - 9'd1;
      if (fs_tick && !fs_step[0] && nr34[6] && len3 == 9'd1) en3 <= 1'b0;
      if (tr[2]) {en3, tmr3, pos3} <= {nr30[7], per3 - 13'd1, 5'd0};
      if (tr[2] && len3 == 9'd0) len3 <= LEN_WAVE;
      if (!nr30[7]) en3 <= 1'b0;
      out3 <= en3 && nr32[6:5] != 2'd0 ? smp >> (nr32[6:5] - 2'd1) : 4'd0;
      tmr4 <= tmr4 == 22'd0 ? per4 - 22'd1 : tmr4 - 22'd1;
      if (tmr4 == 22'd0) lfsr <= lfsr_nx;
      if (ld[3]) len4 <= LEN_SQ - {1'b0, regs[ri(A_NR41)][5:0]};
      if (fs_tick && !fs_step[0] && nr44[6] && len4 != 7'd0) len4 <= len4 - 7'd1;
      if (fs_tick && !fs_step[0] && nr44[6] && len4 == 7'd1) en4 <= 1'b0;
      if (fs_tick && fs_step == 3'd7 && nr42[2:0] != 3'd0) etmr4 <= etmr4 <= 3'd1 ? nr42[2:0] : etmr4 - 3'd1;
      if (fs_tick && fs_step == 3'd7 && nr42[2:0] != 3'd0 && etmr4 <= 3'd1) vol4 <= env_step(vol4, nr42[3]);
      if (tr[3]) {en4, tmr4, lfsr, vol4, etmr4} <= {|nr42[7:3], per4 - 22'd1, 15'h7FFF, nr42[7:4], nr42[2:0]};
      if (tr[3] && len4 == 7'd0) len4 <= LEN_SQ;
      if (nr42[7:3] == 5'd0) en4 <= 1'b0;
      out4 <= en4 && !lfsr[0] ? vol4 : 4'd0;
    end
  assign cv = {en4 ? out4 : 4'd0, en3 ? out3 : 4'd0, en2 ? out2 : 4'd0, en1 ? out1 : 4'd0};
  assign bus.left = pwr ? mix(regs[ri(A_NR51)][7:4], cv, regs[ri(A_NR50)][6:4]) : 20'd0;
  assign bus.right = pwr ? mix(regs[ri(A_NR51)][3:0], cv, regs[ri(A_NR50)][2:0]) : 20'd0;
  always_comb
    bus.dout = !bus.rd || bus.a < A_NR10 || bus.a > A_END ? 8'hFF
      : bus.a == A_NR52 ? {pwr, 3'b111, pwr ? en : 4'h0}
      : bus.a >= A_WAVE ? wave[bus.a[3:0]]
      : bus.a == 16'hFF15 || bus.a == 16'hFF1F || bus.a > A_NR52 ? 8'hFF
      : regs[ri(bus.a)];
endmodule

// File: tb/tb_gb_sound.sv
// tb_gb_sound: directed self-checking bench for the gb_sound APU
module tb_gb_sound;
  logic clk = 1'b0;
  logic rst;
  int n_cmp = 0;
  int n_err = 0;
  gb_sound_if bus ();
  gb_sound dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d (0x%0h) expected %0d (0x%0h)", tag, obs, obs, exp, exp);
    end
  endtask

  task automatic wr_reg(input logic [15:0] ad, input logic [7:0] d);
    @(negedge clk);
    bus.a = ad;
    bus.din = d;
    bus.wr = 1'b1;
    @(negedge clk);
    bus.wr = 1'b0;
  endtask

  task automatic rd_reg(input logic [15:0] ad, output logic [7:0] d);
    @(negedge clk);
    bus.a = ad;
    bus.rd = 1'b1;
    #1 d = bus.dout;
    bus.rd = 1'b0;
  endtask

  task automatic chk_rd(input string tag, input logic [15:0] ad, input logic [7:0] exp);
    logic [7:0] d;
    rd_reg(ad, d);
    chk(tag, {24'd0, d}, {24'd0, exp});
  endtask

  initial begin
    logic [7:0] d;
    logic [14:0] lf;
    logic x;
    int t, s;
    bus.a = 16'h0000;
    bus.din = 8'h00;
    bus.rd = 1'b0;
    bus.wr = 1'b0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    // reset state
    chk("rst_left", {12'd0, bus.left}, 0);
    chk("rst_right", {12'd0, bus.right}, 0);
    chk_rd("rst_nr52", 16'hFF26, 8'h70);
    chk_rd("rst_wave0", 16'hFF30, 8'h00);
    @(negedge clk);
    bus.a = 16'hFF26;
    bus.rd = 1'b0;
    #1 chk("rd_low_ff", {24'd0, bus.dout}, 32'hFF);
    // power on and ch1 square, 50% duty, 4000 clk period
    wr_reg(16'hFF26, 8'h80);
    chk_rd("unused_ff15", 16'hFF15, 8'hFF);
    chk_rd("unused_ff27", 16'hFF27, 8'hFF);
    chk_rd("outside_ff40", 16'hFF40, 8'hFF);
    wr_reg(16'hFF11, 8'h80);
    wr_reg(16'hFF12, 8'hF3);
    wr_reg(16'hFF25, 8'hF3);
    wr_reg(16'hFF24, 8'h77);
    wr_reg(16'hFF13, 8'h83);
    chk_rd("nr13_readback", 16'hFF13, 8'h83);
    wr_reg(16'hFF14, 8'h87);
    repeat (250) @(negedge clk);
    chk("sq_hi0_left", {12'd0, bus.left}, 245760);
    chk("sq_hi0_right", {12'd0, bus.right}, 245760);
    repeat (1250) @(negedge clk);
    chk("sq_lo0_left", {12'd0, bus.left}, 0);
    chk("sq_lo0_right", {12'd0, bus.right}, 0);
    repeat (2000) @(negedge clk);
    chk("sq_hi1_left", {12'd0, bus.left}, 245760);
    repeat (2000) @(negedge clk);
    chk("sq_lo1_left", {12'd0, bus.left}, 0);
    chk_rd("sq_nr52", 16'hFF26, 8'hF1);
    // DAC off kills ch1
    wr_reg(16'hFF12, 8'h00);
    chk_rd("dac_off_nr52", 16'hFF26, 8'hF0);
    // wave channel: ramp up then down, 254 clk per sample
    for (int i = 0; i < 8; i++) wr_reg(16'hFF30 + 16'(i), {4'(2 * i), 4'(2 * i + 1)});
    for (int i = 8; i < 15; i++) wr_reg(16'hFF30 + 16'(i), {4'(30 - 2 * i), 4'(29 - 2 * i)});
    wr_reg(16'hFF3F, 8'h00);
    chk_rd("wave_rd_ff37", 16'hFF37, 8'hEF);
    chk_rd("wave_rd_ff38", 16'hFF38, 8'hED);
    wr_reg(16'hFF1A, 8'h80);
    wr_reg(16'hFF1C, 8'h20);
    wr_reg(16'hFF1D, 8'h81);
    wr_reg(16'hFF1E, 8'h87);
    repeat (129) @(negedge clk);
    for (int k = 0; k < 34; k++) begin
      s = (k % 32) < 16 ? (k % 32) : ((k % 32) < 31 ? 30 - (k % 32) : 0);
      chk($sformatf("wave_smp%0d", k), {12'd0, bus.left}, s * 8 * 2048);
      repeat (254) @(negedge clk);
    end
    chk("wave_right", {12'd0, bus.right}, 0);
    chk_rd("wave_nr52", 16'hFF26, 8'hF4);
    // length: counter of 1 expires on the next length step
    wr_reg(16'hFF1A, 8'h00);
    wr_reg(16'hFF11, 8'h3F);
    wr_reg(16'hFF12, 8'hF0);
    wr_reg(16'hFF14, 8'hC7);
    chk_rd("len_on_nr52", 16'hFF26, 8'hF1);
    d = 8'hF1;
    for (t = 0; t < 20000 && d[0]; t++) rd_reg(16'hFF26, d);
    chk("len_expired", {31'd0, t < 20000}, 1);
    repeat (2) @(negedge clk);
    chk_rd("len_off_nr52", 16'hFF26, 8'hF0);
    chk("len_off_left", {12'd0, bus.left}, 0);
    // noise: 7-bit LFSR, 8 clk per step
    wr_reg(16'hFF21, 8'hF0);
    wr_reg(16'hFF22, 8'h08);
    wr_reg(16'hFF23, 8'h80);
    lf = 15'h7FFF;
    repeat (6) @(negedge clk);
    for (int k = 0; k < 130; k++) begin
      chk($sformatf("noise_step%0d", k), {12'd0, bus.left}, lf[0] ? 0 : 245760);
      x = lf[0] ^ lf[1];
      lf = {x, lf[14:1]};
      lf[6] = x;
      repeat (8) @(negedge clk);
    end
    chk("noise_right", {12'd0, bus.right}, 0);
    chk_rd("noise_nr52", 16'hFF26, 8'hF8);
    // power off
    wr_reg(16'hFF26, 8'h00);
    chk_rd("off_nr12", 16'hFF12, 8'h00);
    chk_rd("off_nr25", 16'hFF25, 8'h00);
    chk_rd("off_nr52", 16'hFF26, 8'h70);
    chk_rd("off_wave_kept", 16'hFF30, 8'h01);
    chk("off_left", {12'd0, bus.left}, 0);
    chk("off_right", {12'd0, bus.right}, 0);
    wr_reg(16'hFF12, 8'hF0);
    chk_rd("off_wr_ignored", 16'hFF12, 8'h00);
    wr_reg(16'hFF3F, 8'h5A);
    chk_rd("off_wave_wr", 16'hFF3F, 8'h5A);
    wr_reg(16'hFF26, 8'h80);
    chk_rd("on_nr12_clear", 16'hFF12, 8'h00);
    wr_reg(16'hFF12, 8'hF0);
    chk_rd("on_nr12_wr", 16'hFF12, 8'hF0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/gb_sound.md
Name:
gb_sound

Overview:
- Game Boy APU: four sound channels, each with a CPU-visible register file at FF10–FF26, plus wave RAM at FF30–FF3F.
  - ch1: square with envelope and length.
  - ch2: square with envelope and length.
  - ch3: 32-sample wave.
  - ch4: LFSR noise.
- Sits on the CPU I/O bus beside the other FFxx peripherals.
- Mixes the four channels into unsigned 20-bit left and right samples for the audio output path.
- The frequency sweep of ch1 is out of scope. NR10 is storage only.

Parameters:
- FS_DIV, 8192, number of clk cycles per frame-sequencer step. 4.194304 MHz / 8192 = 512 Hz.

Ports:
- clk  in  1  system clock, nominally 4.194304 MHz.
- rst  in  1  reset, synchronous, active-high.
- a  in  16  bus address.
- dout  out  8  read data.
- din  in  8  write data.
- rd  in  1  read strobe.
- wr  in  1  write strobe. Sampled on each rising clk edge.
- left  out  20  left mix.
- right  out  20  right mix.

Behaviour:
- Clocking and reset:
  - One clock, clk. Reset is synchronous and active-high (rst).
  - Reset clears all registers, wave RAM, timers, LFSR, frame sequencer and channel enables. left and right become 0.
- Reads (combinational):
  - dout shows the register at address a when rd=1 and a is in FF10–FF3F. Otherwise dout=FF.
  - Mapped registers read back as their stored value, with these exceptions:
    - NR52 (FF26): {power, 3'b111, ch4..ch1 enabled}.
    - Unused addresses FF15, FF1F and FF27–FF2F read FF.
- Writes:
  - A write occurs on every clk edge where wr=1. Software/bench holds wr for one cycle. A longer hold repeats the write and re-triggers the channel.
  - While power (NR52[7]) is 0:
    - Only NR52 and wave RAM are writable.
    - All other registers read 0 (NR52 reads 70), and left/right are 0.
  - Writing NR52[7]=0 clears every register FF10–FF25 and disables all channels.
- Trigger:
  - Writing NRx4[7]=1 enables the channel, but only if its DAC is on.
  - If the length counter is 0, it is reloaded to the maximum: 64 for ch1/2/4, 256 for ch3.
  - Resets the frequency timer and the duty/sample position.
  - Loads the envelope volume from NRx2[7:4].
  - ch4 only: LFSR set to 7FFF.
- DAC:
  - ch1/2/4: the DAC is off when NRx2[7:3]=0. DAC off disables the channel immediately.
  - ch3: the DAC is NR30[7].
- Length:
  - Writing NRx1 loads the counter: 64−len[5:0], or 256−NR31 for ch3.
  - When NRx4[6]=1, the counter decrements on frame-sequencer steps 0/2/4/6.
  - On reaching 0 the channel is disabled.
- Envelope:
  - Clocked on step 7.
  - Period NRx2[2:0]; period 0 freezes the volume.
  - Direction: bit3 1=up, 0=down. Volume saturates at 0/15.
- Square (ch1/ch2):
  - Timer reload is (2048−f)×4 clocks, with f={NRx4[2:0],NRx3}.
  - An 8-step duty pattern is selected by NRx1[7:6]: 00000001, 10000001, 10000111, 01111110.
  - Output = volume when the duty bit is 1, else 0.
- Wave (ch3):
  - Timer reload is (2048−f)×2 clocks.
  - 32 4-bit samples, high nibble first, position wrapping 31→0.
  - NR32[6:5] sets the shift: 0 mute, 1 ×1, 2 >>1, 3 >>2.
- Noise (ch4):
  - Period = (r=0 ? 8 : 16r) << s clocks, with r=NR43[2:0] and s=NR43[7:4].
  - Each tick: x = b0^b1; shift right; b14=x; if NR43[3] also b6=x.
  - Output = volume when b0=0.
- Mixer (combinational from registered channel outputs; disabled channel = 0):
  - sumL = sum of channels selected by NR51[7:4]; sumR uses NR51[3:0] (bit order ch4..ch1).
  - left = (sumL×(NR50[6:4]+1)) << 11. right uses NR50[2:0] in place of NR50[6:4].
  - Max value 480<<11 < 2^20, so there is no overflow.

Decomposition:
- Package gb_sound_pkg holds:
  - Register address constants.
  - Duty pattern table.
  - Length maxima.
  - FS_DIV default.
- Sub-module gb_sound_square (timer, duty, envelope, length) is natural and is instantiated twice.
- Wave, noise, mixer and the register file stay in the top module.

Test Plan:
- Reset → left=right=0; FF26 reads 70; FF30 with rd=1 reads 00.
- Power/regs: FF26=80, FF11=80, FF12=F3, FF25=F3, FF24=77, FF13=83, FF14=87 → ch1 square with period 4000 clk at 50% duty; left alternates 245760/0; right likewise; FF26 reads F1.
- Wave: FF30–FF3F = 01,23,…,EF,ED,…,21,00; FF1A=80, FF1C=20, FF1D=81, FF1E=87 → new sample every 254 clk in order 0,1,…,15,14,…,0; left = sample×8<<11.
- Length: FF11=3F, FF12=F0, FF14=C7 → ch1 disabled at the next length step; FF26 bit0 clears and left returns to 0.
- Noise: FF21=F0, FF22=08 (7-bit, r=0, s=0), FF23=80 → output toggles with a 127-step period at 8 clk/step.
- Power-off: FF26=00 → FF10–FF25 read 0, left=right=0, wave RAM retained; writes to FF12 ignored until FF26=80.
